simple_dual_ram_arbiter: RTL and testbench

Shares one simple dual-port block RAM between two write requesters and one read requester in the GPU memory path, e.g. CPU and rasterizer writes into a tile/line buffer while scanout reads it. Write requests are arbitrated round-robin onto the RAM write port. Reads are issued on the RAM read port and return with a registered valid strobe. Reads that collide with a same-cycle write to the same address are stalled, so the RAM never sees simultaneous read and write of one entry.

---
 rtl/simple_dual_ram_arbiter.sv | 66 ++++++
 tb/tb_simple_dual_ram_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/simple_dual_ram_arbiter.sv
// rtl/simple_dual_ram_arbiter.sv - round-robin write arbiter and collision-stalled read port for a simple dual-port RAM
module simple_dual_ram_arbiter #(
    parameter  int SIZE  = 8,
    parameter  int DEPTH = 256,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            a_valid,
    input  logic [AW-1:0]   a_addr,
    input  logic [SIZE-1:0] a_data,
    output logic            a_ready,
    input  logic            b_valid,
    input  logic [AW-1:0]   b_addr,
    input  logic [SIZE-1:0] b_data,
    output logic            b_ready,
    input  logic            rd_valid,
    input  logic [AW-1:0]   rd_addr,
    output logic            rd_ready,
    output logic            rd_data_valid,
    output logic [SIZE-1:0] rd_data,
    output logic [AW-1:0]   ram_waddr,
    output logic [SIZE-1:0] ram_write_data,
    output logic            ram_write_en,
    output logic [AW-1:0]   ram_raddr,
    input  logic [SIZE-1:0] ram_read_data
);

    logic r_last_grant_b;
    logic r_rd_data_valid;
    logic w_grant_a;
    logic w_grant_b;
    logic w_collide;

    // rst_n gates the grants so nothing is accepted while reset is held
    always_comb begin
        w_grant_a = rst_n & a_valid & (~b_valid | r_last_grant_b);
        w_grant_b = rst_n & b_valid & (~a_valid | ~r_last_grant_b);
    end

    assign a_ready        = w_grant_a;
    assign b_ready        = w_grant_b;
    assign ram_write_en   = w_grant_a | w_grant_b;
    assign ram_waddr      = w_grant_b ? b_addr : a_addr;
    assign ram_write_data = w_grant_b ? b_data : a_data;

    // A read of the entry being written this cycle waits one cycle so it sees the new data
    assign ram_raddr     = rd_addr;
    assign w_collide     = ram_write_en & (ram_waddr == rd_addr);
    assign rd_ready      = rst_n & rd_valid & ~w_collide;
    assign rd_data_valid = r_rd_data_valid;
    assign rd_data       = ram_read_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant_b  <= 1'b1;
            r_rd_data_valid <= 1'b0;
        end else begin
            if (ram_write_en) begin
                r_last_grant_b <= w_grant_b;
            end
            r_rd_data_valid <= rd_valid & rd_ready;
        end
    end

endmodule

// File: tb/tb_simple_dual_ram_arbiter.sv
// tb/tb_simple_dual_ram_arbiter.sv - self-checking bench for simple_dual_ram_arbiter
module tb_simple_dual_ram_arbiter;
    localparam int SIZE = 8;
    localparam int AW   = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            a_valid = 1'b0, b_valid = 1'b0, rd_valid = 1'b0;
    logic [AW-1:0]   a_addr = '0, b_addr = '0, rd_addr = '0;
    logic [SIZE-1:0] a_data = '0, b_data = '0;
    logic            a_ready, b_ready, rd_ready, rd_data_valid, ram_write_en;
    logic [SIZE-1:0] rd_data, ram_write_data;
    logic [SIZE-1:0] ram_read_data = '0;
    logic [AW-1:0]   ram_waddr, ram_raddr;
    logic [SIZE-1:0] ram_mem [256];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    simple_dual_ram_arbiter #(.SIZE(SIZE), .DEPTH(256)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
        .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_ready(rd_ready),
        .rd_data_valid(rd_data_valid), .rd_data(rd_data),
        .ram_waddr(ram_waddr), .ram_write_data(ram_write_data), .ram_write_en(ram_write_en),
        .ram_raddr(ram_raddr), .ram_read_data(ram_read_data)
    );

    // External RAM: synchronous write, registered read
    always @(posedge clk) begin
        if (ram_write_en) ram_mem[ram_waddr] <= ram_write_data;
        ram_read_data <= ram_mem[ram_raddr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        a_valid = 1'b0; b_valid = 1'b0; rd_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        clear_inputs();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a_valid = 1'b1; b_valid = 1'b1; rd_valid = 1'b1;
        a_addr = 8'h01; b_addr = 8'h02; rd_addr = 8'h03;
        tick();
        @(negedge clk);
        checks++;
        if ({a_ready, b_ready, rd_ready, ram_write_en, rd_data_valid} !== 5'b0) begin
            errors++;
            $display("FAIL reset_outputs: got a/b/rd/we/dv=%b required 00000",
                     {a_ready, b_ready, rd_ready, ram_write_en, rd_data_valid});
        end
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_first_grant: got a_ready=%b b_ready=%b required 1 0", a_ready, b_ready);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_contention();
        pulse_reset();
        a_valid = 1'b1; a_addr = 8'h10; a_data = 8'hAA;
        b_valid = 1'b1; b_addr = 8'h20; b_data = 8'hBB;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (a_ready !== (i % 2 == 0) || b_ready !== (i % 2 == 1) || ram_write_en !== 1'b1) begin
                errors++;
                $display("FAIL contention_grant[%0d]: got a=%b b=%b we=%b required a=%0d b=%0d we=1",
                         i, a_ready, b_ready, ram_write_en, i % 2 == 0, i % 2 == 1);
            end
            checks++;
            if (ram_waddr !== ((i % 2 == 0) ? 8'h10 : 8'h20) ||
                ram_write_data !== ((i % 2 == 0) ? 8'hAA : 8'hBB)) begin
                errors++;
                $display("FAIL contention_addr[%0d]: got addr=%h data=%h", i, ram_waddr, ram_write_data);
            end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_single();
        pulse_reset();
        b_valid = 1'b1; b_addr = 8'h30; b_data = 8'h11;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (b_ready !== 1'b1 || a_ready !== 1'b0 || ram_waddr !== 8'h30) begin
                errors++;
                $display("FAIL single_b[%0d]: got b_ready=%b a_ready=%b waddr=%h required 1 0 30",
                         i, b_ready, a_ready, ram_waddr);
            end
            tick();
        end
        a_valid = 1'b1; a_addr = 8'h31; a_data = 8'h22;
        @(negedge clk);
        checks++;
        if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
            errors++;
            $display("FAIL single_then_both: got a_ready=%b b_ready=%b required 1 0", a_ready, b_ready);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_read_latency();
        a_valid = 1'b1; a_addr = 8'h03; a_data = 8'h5C;
        @(negedge clk);
        checks++;
        if (a_ready !== 1'b1) begin
            errors++;
            $display("FAIL latency_write: got a_ready=%b required 1", a_ready);
        end
        tick();
        a_valid = 1'b0;
        rd_valid = 1'b1; rd_addr = 8'h03;
        @(negedge clk);
        checks++;
        if (rd_ready !== 1'b1) begin
            errors++;
            $display("FAIL latency_rd_ready: got %b required 1", rd_ready);
        end
        tick();
        rd_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (rd_data_valid !== 1'b1 || rd_data !== 8'h5C) begin
            errors++;
            $display("FAIL latency_data: got dv=%b data=%h required 1 5c", rd_data_valid, rd_data);
        end
        tick();
    endtask

    task automatic test_collision();
        a_valid = 1'b1; a_addr = 8'h09; a_data = 8'h77;
        rd_valid = 1'b1; rd_addr = 8'h09;
        @(negedge clk);
        checks++;
        if (rd_ready !== 1'b0 || ram_write_en !== 1'b1 || a_ready !== 1'b1) begin
            errors++;
            $display("FAIL collision_stall: got rd_ready=%b we=%b a_ready=%b required 0 1 1",
                     rd_ready, ram_write_en, a_ready);
        end
        tick();
        a_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (rd_ready !== 1'b1 || rd_data_valid !== 1'b0) begin
            errors++;
            $display("FAIL collision_accept: got rd_ready=%b dv=%b required 1 0", rd_ready, rd_data_valid);
        end
        tick();
        rd_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (rd_data_valid !== 1'b1 || rd_data !== 8'h77) begin
            errors++;
            $display("FAIL collision_data: got dv=%b data=%h required 1 77", rd_data_valid, rd_data);
        end
        tick();
    endtask

    task automatic test_reset_mid_read();
        rd_valid = 1'b1; rd_addr = 8'h03;
        tick();
        checks++;
        if (rd_data_valid !== 1'b1) begin
            errors++;
            $display("FAIL midreset_pre: got dv=%b required 1", rd_data_valid);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (rd_data_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_async_clear: got dv=%b required 0", rd_data_valid);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (rd_ready !== 1'b1) begin
            errors++;
            $display("FAIL midreset_rd_ready: got %b required 1", rd_ready);
        end
        #1;
        rst_n = 1'b0;
        a_valid = 1'b1; a_addr = 8'h05; a_data = 8'h66;
        b_valid = 1'b1; b_addr = 8'h06; b_data = 8'h67;
        tick();
        checks++;
        if (rd_data_valid !== 1'b0 || a_ready !== 1'b0 || b_ready !== 1'b0) begin
            errors++;
            $display("FAIL midreset_held: got dv=%b a=%b b=%b required 0 0 0", rd_data_valid, a_ready, b_ready);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (a_ready !== 1'b1 || b_ready !== 1'b0 || rd_ready !== 1'b1) begin
            errors++;
            $display("FAIL midreset_resume: got a=%b b=%b rd=%b required 1 0 1", a_ready, b_ready, rd_ready);
        end
        tick();
        clear_inputs();
        @(negedge clk);
        checks++;
        if (rd_data_valid !== 1'b1 || rd_data !== 8'h5C) begin
            errors++;
            $display("FAIL midreset_read_data: got dv=%b data=%h required 1 5c", rd_data_valid, rd_data);
        end
        tick();
    endtask

    task automatic test_random();
        bit              m_last_b;
        logic [SIZE-1:0] m_mem   [4];
        bit              m_known [4];
        bit              m_dv, m_dknown;
        logic [SIZE-1:0] m_d;
        bit              e_a, e_b, e_we, e_rd;
        logic [AW-1:0]   e_waddr;
        logic [SIZE-1:0] e_wdata;
        int              a_wait, b_wait;
        m_last_b = 1'b1; m_dv = 1'b0; m_dknown = 1'b0; m_d = '0;
        e_a = 1'b0; e_b = 1'b0; e_rd = 1'b0;
        a_wait = 0; b_wait = 0;
        for (int k = 0; k < 4; k++) m_known[k] = 1'b0;
        pulse_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            // Pending requests keep their address/data until accepted
            if (!(a_valid && !e_a)) begin
                a_valid = ($urandom_range(0, 3) != 0);
                a_addr  = AW'($urandom_range(0, 3));
                a_data  = SIZE'($urandom);
            end
            if (!(b_valid && !e_b)) begin
                b_valid = ($urandom_range(0, 3) != 0);
                b_addr  = AW'($urandom_range(0, 3));
                b_data  = SIZE'($urandom);
            end
            if (!(rd_valid && !e_rd)) begin
                rd_valid = ($urandom_range(0, 1) != 0);
                rd_addr  = AW'($urandom_range(0, 3));
            end
            e_a = 1'b0; e_b = 1'b0;
            if (a_valid && b_valid) begin
                if (m_last_b) e_a = 1'b1; else e_b = 1'b1;
            end else if (a_valid) e_a = 1'b1;
            else if (b_valid) e_b = 1'b1;
            e_we    = e_a || e_b;
            e_waddr = e_b ? b_addr : a_addr;
            e_wdata = e_b ? b_data : a_data;
            e_rd    = rd_valid && !(e_we && e_waddr == rd_addr);
            @(negedge clk);
            checks++;
            if (a_ready !== e_a || b_ready !== e_b || rd_ready !== e_rd || ram_write_en !== e_we) begin
                errors++;
                $display("FAIL rand_ready[%0d]: got a/b/rd/we=%b%b%b%b required %b%b%b%b",
                         cyc, a_ready, b_ready, rd_ready, ram_write_en, e_a, e_b, e_rd, e_we);
            end
            if (e_we) begin
                checks++;
                if (ram_waddr !== e_waddr || ram_write_data !== e_wdata) begin
                    errors++;
                    $display("FAIL rand_write[%0d]: got %h/%h required %h/%h",
                             cyc, ram_waddr, ram_write_data, e_waddr, e_wdata);
                end
            end
            checks++;
            if (rd_data_valid !== m_dv || (m_dv && m_dknown && rd_data !== m_d)) begin
                errors++;
                $display("FAIL rand_read[%0d]: got dv=%b data=%h required dv=%b data=%h",
                         cyc, rd_data_valid, rd_data, m_dv, m_d);
            end
            a_wait = (a_valid && !a_ready) ? a_wait + 1 : 0;
            b_wait = (b_valid && !b_ready) ? b_wait + 1 : 0;
            checks++;
            if (a_wait > 1 || b_wait > 1) begin
                errors++;
                $display("FAIL rand_fairness[%0d]: got waits a=%0d b=%0d required <=1", cyc, a_wait, b_wait);
            end
            m_dv     = e_rd;
            m_d      = m_mem[rd_addr[1:0]];
            m_dknown = m_known[rd_addr[1:0]];
            if (e_we) begin
                m_mem[e_waddr[1:0]]   = e_wdata;
                m_known[e_waddr[1:0]] = 1'b1;
                m_last_b = e_b;
            end
            tick();
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_contention();
        test_single();
        test_read_latency();
        test_collision();
        test_reset_mid_read();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
